// File: rtl/aes_subshift_serial_umsk.sv
// Byte-serial SubBytes+ShiftRows sequencer for the unmasked AES round datapath.
// A 128-bit state is accepted, then one byte per cycle is sent to an external
// S-box. Each result is written straight into its ShiftRows position, and the
// full result is presented downstream.
//
// state | meaning
// IDLE  | waiting for a state, in_ready=1
// RUN   | issuing 16 bytes to the S-box and capturing its results
// DONE  | result held on out_data with out_valid=1 until out_ready
module aes_subshift_serial_umsk #(
  parameter int SBOX_LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   sbox_in,
  output logic         sbox_in_valid,
  input  logic [7:0]   sbox_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Depth of the capture pipeline. It has at least one stage so that the
  // arrays stay legal when the S-box is combinational.
  localparam int D = (SBOX_LAT > 0) ? SBOX_LAT : 1;

  state_e       st_q;
  logic [127:0] data_q;
  logic [127:0] out_q;
  logic [3:0]   idx_q;
  logic [3:0]   idx_d;
  logic [3:0]   cap_cnt_q;
  logic [7:0]   sbox_in_q;
  logic         sbox_vld_q;
  logic         in_ready_q;
  logic         out_valid_q;

  logic [D-1:0] pv_q;
  logic [3:0]   pi_q [D];
  logic         cap_v;
  logic [3:0]   cap_idx;

  // For output byte j (row r = j%4, column c = j/4), ShiftRows takes the
  // byte from column (c+r)%4 of the same row.
  function automatic logic [3:0] src_of(input logic [3:0] j);
    logic [1:0] col;
    col = j[3:2] + j[1:0];
    return {col, j[1:0]};
  endfunction

  function automatic logic [7:0] byte_of(input logic [127:0] v, input logic [3:0] b);
    return v[8*b +: 8];
  endfunction

  // Compute the index of the next byte to issue.
  always_comb begin
    idx_d = idx_q + 4'd1;
  end

  // Delay issue-valid and issue index so they line up with the S-box result.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q <= '0;
      for (int n = 0; n < D; n++) pi_q[n] <= '0;
    end else begin
      pv_q[0] <= sbox_vld_q;
      pi_q[0] <= idx_q;
      for (int n = 1; n < D; n++) begin
        pv_q[n] <= pv_q[n-1];
        pi_q[n] <= pi_q[n-1];
      end
    end
  end

  // A combinational S-box returns its result in the same cycle as the issue.
  assign cap_v   = (SBOX_LAT == 0) ? sbox_vld_q : pv_q[D-1];
  assign cap_idx = (SBOX_LAT == 0) ? idx_q      : pi_q[D-1];

  // Main sequencer: accept the state, issue bytes, capture results, then hand off.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= IDLE;
      data_q      <= '0;
      out_q       <= '0;
      idx_q       <= '0;
      cap_cnt_q   <= '0;
      sbox_in_q   <= '0;
      sbox_vld_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (st_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            data_q     <= in_data;
            // Output byte 0 comes from source byte 0, so issue 0 loads directly.
            sbox_in_q  <= in_data[7:0];
            sbox_vld_q <= 1'b1;
            idx_q      <= '0;
            cap_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            st_q       <= RUN;
          end
        end
        RUN: begin
          if (sbox_vld_q && idx_q != 4'd15) begin
            idx_q     <= idx_d;
            sbox_in_q <= byte_of(data_q, src_of(idx_d));
          end else begin
            sbox_vld_q <= 1'b0;
            sbox_in_q  <= '0;
          end
          if (cap_v) begin
            out_q[8*cap_idx +: 8] <= sbox_out;
            cap_cnt_q             <= cap_cnt_q + 4'd1;
            if (cap_cnt_q == 4'd15) begin
              st_q        <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            st_q        <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_q;
  assign sbox_in       = sbox_in_q;
  assign sbox_in_valid = sbox_vld_q;

endmodule

// File: tb/tb_aes_subshift_serial_umsk.sv
// Bench for aes_subshift_serial_umsk. It runs one instance with a
// combinational S-box model and a second instance with a two-stage
// registered S-box model.
module tb_aes_subshift_serial_umsk;

  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] C1_IN  = 128'hf0e0d0c0b0a090807060504030201000;
  localparam logic [127:0] C1_EXP = 128'he7d0caba51b770cd04e160098ce05363;
  localparam logic [127:0] ALL63  = {16{8'h63}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] in_data0, out_data0, in_data2, out_data2;
  logic         in_valid0, in_ready0, out_valid0, out_ready0, sbox_in_valid0;
  logic         in_valid2, in_ready2, out_valid2, out_ready2, sbox_in_valid2;
  logic [7:0]   sbox_in0, sbox_out0, sbox_in2, sbox_out2, sb_p1;

  aes_subshift_serial_umsk #(.SBOX_LAT(0)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
    .sbox_in(sbox_in0), .sbox_in_valid(sbox_in_valid0), .sbox_out(sbox_out0)
  );

  aes_subshift_serial_umsk #(.SBOX_LAT(2)) u2 (
    .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sbox_in(sbox_in2), .sbox_in_valid(sbox_in_valid2), .sbox_out(sbox_out2)
  );

  function automatic logic [7:0] sbox(input logic [7:0] x);
    int i;
    i = 2047 - 8 * int'(x);
    return SBOX_FLAT[i -: 8];
  endfunction

  // Reference SubBytes then ShiftRows: state[r][c] <- S(state[r][(c+r)%4]).
  function automatic logic [127:0] ref_ss(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[8*(4*c+r) +: 8] = sbox(x[8*(4*((c+r)%4)+r) +: 8]);
    return y;
  endfunction

  always_comb sbox_out0 = sbox(sbox_in0);

  always @(posedge clk) begin
    sb_p1     <= sbox(sbox_in2);
    sbox_out2 <= sb_p1;
  end

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  logic [127:0] sb_q[$];
  int acc_cyc[$];
  logic [127:0] sb_exp;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // u0 scoreboard: push the expected result on accept, pop it on the output handshake.
  always @(negedge clk) begin
    if (!rst && in_valid0 && in_ready0) begin
      sb_q.push_back(ref_ss(in_data0));
      acc_cyc.push_back(cyc);
    end
    if (!rst && out_valid0 && out_ready0) begin
      if (sb_q.size() == 0) chk(1'b0, "sb_unexpected_out", out_data0, '0);
      else begin
        sb_exp = sb_q.pop_front();
        chk(out_data0 == sb_exp, "sb_data", out_data0, sb_exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one state and check: issue-valid count, out_valid latency, and data.
  task automatic run_vec(input int d, input logic [127:0] din, input logic [127:0] dexp, input string tag);
    int cnt, first, lat;
    logic [127:0] got;
    logic sv, ov, rdy;
    lat = (d == 0) ? 0 : 2;
    rdy = (d == 0) ? in_ready0 : in_ready2;
    chk(rdy == 1'b1, {tag, "_rdy"}, 128'(rdy), 128'd1);
    if (d == 0) begin in_data0 = din; in_valid0 = 1'b1; end
    else begin in_data2 = din; in_valid2 = 1'b1; end
    step();
    in_valid0 = 1'b0;
    in_valid2 = 1'b0;
    cnt = 0; first = 0; got = '0;
    for (int n = 1; n <= 40; n++) begin
      sv = (d == 0) ? sbox_in_valid0 : sbox_in_valid2;
      ov = (d == 0) ? out_valid0 : out_valid2;
      if (sv) cnt++;
      if (ov && first == 0) begin
        first = n;
        got = (d == 0) ? out_data0 : out_data2;
      end
      step();
    end
    chk(cnt == 16, {tag, "_issue_cnt"}, 128'(cnt), 128'd16);
    chk(first == 17 + lat, {tag, "_ov_latency"}, 128'(first), 128'(17 + lat));
    chk(got == dexp, {tag, "_data"}, got, dexp);
  endtask

  // Start a state, assert reset while issue 7 is on the S-box, then check the reset outputs.
  task automatic rst_mid(input int d, input string tag);
    logic sv;
    if (d == 0) begin in_data0 = C1_IN; in_valid0 = 1'b1; end
    else begin in_data2 = C1_IN; in_valid2 = 1'b1; end
    step();
    in_valid0 = 1'b0;
    in_valid2 = 1'b0;
    repeat (7) step();
    sv = (d == 0) ? sbox_in_valid0 : sbox_in_valid2;
    chk(sv == 1'b1, {tag, "_mid_issue"}, 128'(sv), 128'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    if (d == 0) begin
      chk(in_ready0 && !out_valid0 && out_data0 == '0, {tag, "_after_rst"}, out_data0, '0);
      sb_q.delete();
    end else begin
      chk(in_ready2 && !out_valid2 && out_data2 == '0, {tag, "_after_rst"}, out_data2, '0);
    end
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] dexp;
  } vec_t;

  vec_t tab[4];

  initial begin
    int n;
    rst = 1'b1;
    in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b1;
    in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    chk(in_ready0 == 1'b1, "rst_in_ready", 128'(in_ready0), 128'd1);
    chk(out_valid0 == 1'b0, "rst_out_valid", 128'(out_valid0), 128'd0);
    chk(out_data0 == '0, "rst_out_data", out_data0, '0);
    chk(sbox_in_valid0 == 1'b0 && sbox_in0 == 8'd0, "rst_sbox_in", {sbox_in_valid0, sbox_in0}, '0);
    chk(in_ready2 == 1'b1 && out_valid2 == 1'b0, "rst_u2", {in_ready2, out_valid2}, 128'h2);

    tab[0] = '{din: '0,                 dexp: ALL63};
    tab[1] = '{din: C1_IN,              dexp: C1_EXP};
    tab[2] = '{din: {16{8'hff}},        dexp: {16{8'h16}}};
    tab[3] = '{din: 128'h0123456789abcdeffedcba9876543210,
               dexp: ref_ss(128'h0123456789abcdeffedcba9876543210)};
    for (int i = 0; i < 4; i++) run_vec(0, tab[i].din, tab[i].dexp, $sformatf("vec%0d", i));

    // Backpressure: out_data must stay frozen while out_ready is held low.
    out_ready0 = 1'b0;
    in_data0 = C1_IN; in_valid0 = 1'b1;
    step();
    in_valid0 = 1'b0;
    n = 0;
    while (!out_valid0 && n < 40) begin step(); n++; end
    chk(out_valid0 == 1'b1, "bp_ov_rise", 128'(out_valid0), 128'd1);
    for (int k = 0; k < 10; k++) begin
      chk(out_valid0 && out_data0 == C1_EXP && !in_ready0, "bp_hold", out_data0, C1_EXP);
      step();
    end
    out_ready0 = 1'b1;
    step();
    chk(in_ready0 && !out_valid0 && out_data0 == C1_EXP, "bp_release", out_data0, C1_EXP);

    // Back-to-back: in_valid stays high across two states.
    acc_cyc.delete();
    in_data0 = tab[3].din; in_valid0 = 1'b1;
    step();
    in_data0 = C1_IN;
    n = 0;
    while (!in_ready0 && n < 40) begin step(); n++; end
    step();
    in_valid0 = 1'b0;
    if (acc_cyc.size() == 2)
      chk(acc_cyc[1] - acc_cyc[0] == 18, "b2b_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'd18);
    else
      chk(1'b0, "b2b_accepts", 128'(acc_cyc.size()), 128'd2);
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin step(); n++; end
    chk(sb_q.size() == 0, "b2b_drain", 128'(sb_q.size()), 128'd0);

    // Abort mid-RUN, then check that a fresh state leaves no stale bytes.
    rst_mid(0, "u0");
    run_vec(0, '0, ALL63, "u0_post_rst");

    // Registered S-box with two cycles of latency.
    run_vec(2, C1_IN, C1_EXP, "u2_c1");
    rst_mid(2, "u2");
    run_vec(2, '0, ALL63, "u2_post_rst");

    repeat (3) step();
    chk(sb_q.size() == 0, "sb_drain", 128'(sb_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
